// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the derivation of the bit-counter width from the operand width.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;

   // Counter width is clog2(width); never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Purely combinational, gate-level, mirroring the adder cell.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic a_xor_b;

   assign a_xor_b = a ^ b;
   assign d       = a_xor_b ^ bin;
   assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts a/b over a valid/ready handshake,
// computes a - b LSB-first one bit per clock through a single full-subtractor
// cell, then presents diff/borrow/zero over a second valid/ready handshake.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int unsigned   CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             br;
   logic             zacc;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             br_next;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_next)
   );

   // Control FSM plus serial datapath; diff doubles as the result shift
   // register, so it is cleared on load and fills from the MSB end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         diff      <= '0;
         br        <= 1'b0;
         zacc      <= 1'b0;
         cnt       <= '0;
         borrow    <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               if (in_valid && in_ready) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  diff     <= '0;
                  br       <= 1'b0;
                  zacc     <= 1'b1;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               diff <= {d_bit, diff[WIDTH-1:1]};
               br   <= br_next;
               zacc <= zacc & ~d_bit;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  borrow    <= br_next;
                  zero      <= zacc & ~d_bit;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vector table,
// backpressure / mid-run input / async reset sequences, and a random sweep
// checked against plain modulo arithmetic.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         zero;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         borrow;
      logic         zero;
   } vec_t;

   vec_t vecs[6];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for in_ready, then present operands for one accepting edge.
   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_);
      int n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (in_ready !== 1'b1) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      a        = ta;
      b        = tb_;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_checked(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input logic [W-1:0] ed, input logic eb, input logic ez);
      int lat;
      start_op(ta, tb_);
      wait_result(lat);
      chk({name, "_latency"}, lat, 32'd8);
      chk({name, "_diff"}, {24'b0, diff}, {24'b0, ed});
      chk({name, "_borrow"}, {31'b0, borrow}, {31'b0, eb});
      chk({name, "_zero"}, {31'b0, zero}, {31'b0, ez});
      finish_op();
   endtask

   initial begin
      int lat;
      int ra, rb;
      logic [W-1:0] ed;

      vecs[0] = '{a: 8'h5A, b: 8'h3C, diff: 8'h1E, borrow: 1'b0, zero: 1'b0};
      vecs[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1, zero: 1'b0};
      vecs[2] = '{a: 8'hFF, b: 8'h00, diff: 8'hFF, borrow: 1'b0, zero: 1'b0};
      vecs[3] = '{a: 8'h77, b: 8'h77, diff: 8'h00, borrow: 1'b0, zero: 1'b1};
      vecs[4] = '{a: 8'h10, b: 8'h20, diff: 8'hF0, borrow: 1'b1, zero: 1'b0};
      vecs[5] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, zero: 1'b0};

      // Reset state
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #12;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_diff", {24'b0, diff}, 32'd0);
      chk("rst_borrow", {31'b0, borrow}, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed vector table
      for (int i = 0; i < 6; i++)
         run_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                     vecs[i].diff, vecs[i].borrow, vecs[i].zero);

      // Backpressure: result must hold while out_ready is low
      start_op(8'h33, 8'h11);
      wait_result(lat);
      chk("bp_latency", lat, 32'd8);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_diff", {24'b0, diff}, 32'h22);
         chk("bp_borrow", {31'b0, borrow}, 32'd0);
         chk("bp_zero", {31'b0, zero}, 32'd0);
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      finish_op();
      chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
      chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
      run_checked("bp_next", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);

      // Inputs changing during RUN are ignored
      start_op(8'h5A, 8'h3C);
      repeat (3) tick();
      a        = 8'hAA;
      b        = 8'h55;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_result(lat);
      chk("ign_latency", lat + 4, 32'd8);
      chk("ign_diff", {24'b0, diff}, 32'h1E);
      chk("ign_borrow", {31'b0, borrow}, 32'd0);
      finish_op();

      // Asynchronous reset mid-RUN aborts the operation
      start_op(8'h12, 8'h34);
      repeat (3) tick();
      #3 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_diff", {24'b0, diff}, 32'd0);
      chk("arst_borrow", {31'b0, borrow}, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("arst_release_in_ready", {31'b0, in_ready}, 32'd1);
      chk("arst_release_out_valid", {31'b0, out_valid}, 32'd0);
      run_checked("arst_next", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

      // Random sweep against modulo arithmetic
      for (int i = 0; i < 1000; i++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         if (i % 50 == 0) rb = ra;
         ed = W'((ra - rb + 256) % 256);
         run_checked("rnd", W'(ra), W'(rb), ed, ra < rb, ra == rb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
